rx_lane_deserializer: RTL



---
 rtl/rx_lane_deserializer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rx_lane_deserializer.sv
// ============================================================================
// rx_lane_deserializer : per-lane serial-to-word receive front end (COM align,
// COM/IDL strip, 32-bit packing). Optional macro: RX_BYTE_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_lane_deserializer #(
    parameter logic [7:0]  COM_SYM     = 8'hBC,
    parameter logic [7:0]  IDL_SYM     = 8'h7C,
    parameter int unsigned ALIGN_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    output logic [31:0] lane_out,
    output logic        valid_out,
    output logic        lock_out
`ifdef RX_BYTE_COUNT_EN
    ,
    output logic [15:0] byte_cnt_out
`endif
);

    localparam logic [1:0] c_SEARCH = 2'd0;
    localparam logic [1:0] c_ALIGN  = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    localparam logic [3:0] c_ALIGN_CNT = 4'(ALIGN_COUNT);

    logic [1:0]  r_state;
    logic [7:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_com_cnt;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_acc;

    logic [7:0]  w_cand;
    logic        w_boundary;
    logic        w_is_com;
    logic        w_is_idl;
    logic        w_data_accept;
    logic [3:0]  w_com_next;

    // The candidate byte includes the bit being sampled on this edge.
    assign w_cand        = {r_sr[6:0], data_in};
    assign w_boundary    = (r_bit_cnt == 3'd7);
    assign w_is_com      = (w_cand == COM_SYM);
    assign w_is_idl      = (w_cand == IDL_SYM);
    assign w_com_next    = r_com_cnt + 4'd1;
    assign w_data_accept = (r_state == c_LOCKED) && w_boundary && !w_is_com && !w_is_idl;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_SEARCH;
            r_sr       <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_com_cnt  <= 4'd0;
            r_byte_idx <= 2'd0;
            r_acc      <= 24'd0;
            lane_out   <= 32'd0;
            valid_out  <= 1'b0;
            lock_out   <= 1'b0;
        end else begin
            r_sr      <= w_cand;
            valid_out <= 1'b0;
            case (r_state)
                c_SEARCH: begin
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        r_com_cnt <= 4'd1;
                        r_state   <= c_ALIGN;
                    end
                end
                c_ALIGN: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_com) begin
                            r_com_cnt <= w_com_next;
                            if (w_com_next == c_ALIGN_CNT) begin
                                r_state  <= c_LOCKED;
                                lock_out <= 1'b1;
                            end
                        end else begin
                            r_com_cnt <= 4'd0;
                            r_state   <= c_SEARCH;
                        end
                    end
                end
                c_LOCKED: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_data_accept) begin
                        // The fourth byte goes straight to the output; byte_idx wraps to 0.
                        case (r_byte_idx)
                            2'd0: r_acc[23:16] <= w_cand;
                            2'd1: r_acc[15:8]  <= w_cand;
                            2'd2: r_acc[7:0]   <= w_cand;
                            default: begin
                                lane_out  <= {r_acc, w_cand};
                                valid_out <= 1'b1;
                            end
                        endcase
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                default: r_state <= c_SEARCH;
            endcase
        end
    end

`ifdef RX_BYTE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt_out <= 16'd0;
        end else if (w_data_accept && (byte_cnt_out != 16'hFFFF)) begin
            byte_cnt_out <= byte_cnt_out + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
